commit_ring_ctrl: RTL and testbench
===================================

# commit_ring_ctrl

Allocation/retirement controller for one hart's ring of NCOMMIT commit stations. It is the commit-side counterpart of the rename stage. It hands out the next free station index and free-slot count to rename, and accepts the per-cycle allocation count back. It retires completed stations in program order, up to NRETIRE per clock, and publishes a one-hot retired mask that the scoreboards use to drop stale renames. It also rewinds the ring on branch mispredicts and traps.

## Interface

Parameters:
- NCOMMIT, 32, number of commit stations; a power of two equal to 2**LNCOMMIT
- LNCOMMIT, 5, station index width
- NDEC, 4, decode width; at most 2*NDEC stations are allocated per clock
- NRETIRE, 4, maximum stations retired per clock (1..8)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- alloc_count  in  LNCOMMIT  stations rename is allocating this clock (0..2*NDEC)
- commit_done  in  NCOMMIT  level, per station: the result is complete and the station may retire
- commit_br_enable  in  1  mispredict; stations strictly younger than commit_br_addr are discarded
- commit_br_addr  in  LNCOMMIT  mispredicting station
- commit_trap_br_enable  in  1  trap; commit_trap_br_addr and all younger stations are discarded
- commit_trap_br_addr  in  LNCOMMIT  trapping station
- next_start  out  LNCOMMIT  index of the next station to allocate (the out pointer)
- current_available  out  LNCOMMIT+1  free stations, equal to NCOMMIT - count
- commit_reg  out  NCOMMIT  registered one-hot-per-station mask of stations retired on the previous edge
- retire_count  out  $clog2(NRETIRE+1)  registered popcount of commit_reg
- ring_empty  out  1  count==0
- ring_full  out  1  count==NCOMMIT

## Operation

State:
- in_ptr: oldest live station, LNCOMMIT bits.
- out_ptr: next free station, LNCOMMIT bits.
- count: live stations, LNCOMMIT+1 bits.
- All pointer arithmetic is modulo NCOMMIT. count distinguishes full from empty.

Live set:
- A station is live when it lies in in_ptr .. in_ptr+count-1.
- A station's distance is (idx - in_ptr) mod NCOMMIT.

Retire (every clock):
- Compute k = the number of consecutive stations starting at in_ptr whose commit_done bit is 1.
- k stops at the first 0, at count, at NRETIRE, and at the flush limit below.
- Those k stations set their bits in the next commit_reg, and in_ptr advances by k.
- A done bit on a non-live station is ignored.

Allocate:
- Applies when no flush is active and alloc_count <= current_available.
- out_ptr += alloc_count and count += alloc_count.
- If alloc_count > current_available, the allocation is dropped entirely (no partial allocation).

Branch flush (commit_br_enable):
- Applies only if commit_br_addr is live; otherwise it is ignored.
- out_ptr <= commit_br_addr + 1.
- Retirement may include commit_br_addr itself.
- count <= distance(commit_br_addr) + 1 - k.
- alloc_count is ignored this clock.

Trap flush (commit_trap_br_enable):
- Has priority over a branch flush in the same clock.
- Applies only if commit_trap_br_addr is live.
- out_ptr <= commit_trap_br_addr.
- Retirement is limited to stations with distance < distance(commit_trap_br_addr).
- count <= distance(commit_trap_br_addr) - k. If the trap address equals in_ptr, the ring becomes empty.
- alloc_count is ignored this clock.

Count update without a flush: count <= count + alloc - k.

## Timing

Reset values:
- in_ptr=0, out_ptr=0, count=0.
- commit_reg=0, retire_count=0.
- next_start=0, current_available=NCOMMIT, ring_empty=1, ring_full=0.
- Reset overrides allocation, retirement and flush in the same clock.
- Reset asserted mid-operation discards all live stations.

Output timing:
- next_start, current_available, ring_empty and ring_full are combinational from registers. They reflect the state after the last edge.
- Allocation at edge t is visible in next_start and current_available after edge t.
- Retirement decided in cycle t produces commit_reg and retire_count, valid for exactly one cycle after edge t.
- Slots freed by retirement are allocatable from cycle t+1.
- Retiring and allocating in the same clock is legal. Availability is checked against the pre-retire current_available.
- commit_reg is 0 on any cycle that follows an edge with k=0.

## Test plan

- Reset, then alloc_count=3 for one clock, then commit_done[2:0]=3'b111 → commit_reg=0x7 and retire_count=3 for one cycle; afterwards next_start=3, current_available=32, ring_empty=1.
- Allocate 8 per clock for 4 clocks → ring_full=1 and current_available=0. A further alloc_count=1 is dropped and next_start stays 0. Then commit_done=all-ones → retire 4 per clock over 8 clocks.
- in_ptr=30, count=4 (stations 30, 31, 0, 1), all done, NRETIRE=4 → commit_reg=0x_C000_0003 (bits 30, 31, 0, 1), in_ptr=2 (wrap-around).
- Stations 0..5 live and done bits {0,1,3} set → retire only 0 and 1; station 3 retires only after station 2's done bit is set.
- Stations 0..9 live, commit_br_enable at addr 4 with alloc_count=2 in the same clock → next_start=5, count=5, allocation ignored. A branch at addr 12 (not live) is ignored.
- Stations 0..5 live with station 0 done, trap at addr 0 → ring_empty=1, next_start=0, commit_reg=0. A trap and a branch in the same clock → the trap wins.

Source files
------------

// File: rtl/commit_ring_ctrl.sv
// commit_ring_ctrl
//
// Allocation and retirement controller for one hart's ring of NCOMMIT commit
// stations. Rename reads next_start and current_available and returns the
// number of stations it claims each clock. Completed stations retire in
// program order, up to NRETIRE per clock, and are published as a one-hot
// mask so the scoreboards can drop stale renames. Branch mispredicts and
// traps rewind the allocation pointer.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   alloc_count             stations rename allocates this clock (0..2*NDEC)
//   commit_done             per-station completion level
//   commit_br_enable/addr   mispredict: stations younger than addr discarded
//   commit_trap_br_enable/addr  trap: addr and everything younger discarded
//   next_start              next station to allocate (out pointer)
//   current_available       free stations (NCOMMIT - count)
//   commit_reg              stations retired on the previous edge (one-hot)
//   retire_count            popcount of commit_reg
//   ring_empty, ring_full   occupancy flags
module commit_ring_ctrl #(
    parameter int NCOMMIT  = 32,
    parameter int LNCOMMIT = 5,
    parameter int NDEC     = 4,
    parameter int NRETIRE  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [LNCOMMIT-1:0]          alloc_count,
    input  logic [NCOMMIT-1:0]           commit_done,
    input  logic                         commit_br_enable,
    input  logic [LNCOMMIT-1:0]          commit_br_addr,
    input  logic                         commit_trap_br_enable,
    input  logic [LNCOMMIT-1:0]          commit_trap_br_addr,
    output logic [LNCOMMIT-1:0]          next_start,
    output logic [LNCOMMIT:0]            current_available,
    output logic [NCOMMIT-1:0]           commit_reg,
    output logic [$clog2(NRETIRE+1)-1:0] retire_count,
    output logic                         ring_empty,
    output logic                         ring_full
);

    localparam int                RCW       = $clog2(NRETIRE + 1);
    localparam logic [LNCOMMIT:0] FULL_CNT  = (LNCOMMIT + 1)'(NCOMMIT);
    localparam logic [LNCOMMIT:0] RET_MAX   = (LNCOMMIT + 1)'(NRETIRE);
    localparam logic [LNCOMMIT:0] ALLOC_MAX = (LNCOMMIT + 1)'(2 * NDEC);

    // Ring state
    logic [LNCOMMIT-1:0] in_ptr;
    logic [LNCOMMIT-1:0] out_ptr;
    logic [LNCOMMIT:0]   count;

    // Next-state / decision signals
    logic [LNCOMMIT-1:0] in_ptr_nxt;
    logic [LNCOMMIT-1:0] out_ptr_nxt;
    logic [LNCOMMIT:0]   count_nxt;
    logic [LNCOMMIT-1:0] trap_dist;
    logic [LNCOMMIT-1:0] br_dist;
    logic                trap_ok;
    logic                br_ok;
    logic                alloc_ok;
    logic [LNCOMMIT:0]   ret_limit;
    logic [LNCOMMIT:0]   ret_k;
    logic [NCOMMIT-1:0]  ret_mask;
    logic                ret_run;
    logic [LNCOMMIT-1:0] slot;

    // Distance of a station from the oldest live one; wraps with the index width.
    function automatic logic [LNCOMMIT-1:0] ring_dist(input logic [LNCOMMIT-1:0] idx,
                                                      input logic [LNCOMMIT-1:0] base);
        return idx - base;
    endfunction

    function automatic logic [LNCOMMIT:0] min_cnt(input logic [LNCOMMIT:0] a,
                                                  input logic [LNCOMMIT:0] b);
        return (a < b) ? a : b;
    endfunction

    assign next_start        = out_ptr;
    assign current_available = FULL_CNT - count;
    assign ring_empty        = (count == '0);
    assign ring_full         = (count == FULL_CNT);

    // ---- Stage: flush qualification and in-order retire selection ----
    always_comb begin
        trap_dist = ring_dist(commit_trap_br_addr, in_ptr);
        br_dist   = ring_dist(commit_br_addr, in_ptr);
        // A flush only counts when its station is live; the trap outranks the branch.
        trap_ok   = commit_trap_br_enable && ({1'b0, trap_dist} < count);
        br_ok     = commit_br_enable && ({1'b0, br_dist} < count) && !trap_ok;

        // Never retire a station that the flush in this same clock discards.
        ret_limit = min_cnt(count, RET_MAX);
        if (trap_ok) begin
            ret_limit = min_cnt(ret_limit, {1'b0, trap_dist});
        end else if (br_ok) begin
            ret_limit = min_cnt(ret_limit, {1'b0, br_dist} + 1'b1);
        end

        ret_k    = '0;
        ret_mask = '0;
        ret_run  = 1'b1;
        slot     = in_ptr;
        for (int i = 0; i < NRETIRE; i++) begin
            slot = in_ptr + LNCOMMIT'(i);
            // The run stops at the first incomplete station to keep program order.
            if (ret_run && ((LNCOMMIT + 1)'(i) < ret_limit) && commit_done[slot]) begin
                ret_mask[slot] = 1'b1;
                ret_k          = ret_k + 1'b1;
            end else begin
                ret_run = 1'b0;
            end
        end

        // Availability uses the pre-retire free count; oversize requests are dropped whole.
        alloc_ok = !trap_ok && !br_ok &&
                   ({1'b0, alloc_count} <= current_available) &&
                   ({1'b0, alloc_count} <= ALLOC_MAX);

        in_ptr_nxt = in_ptr + ret_k[LNCOMMIT-1:0];
        if (trap_ok) begin
            out_ptr_nxt = commit_trap_br_addr;
            count_nxt   = {1'b0, trap_dist} - ret_k;
        end else if (br_ok) begin
            out_ptr_nxt = commit_br_addr + 1'b1;
            count_nxt   = {1'b0, br_dist} + 1'b1 - ret_k;
        end else if (alloc_ok) begin
            out_ptr_nxt = out_ptr + alloc_count;
            count_nxt   = count + {1'b0, alloc_count} - ret_k;
        end else begin
            out_ptr_nxt = out_ptr;
            count_nxt   = count - ret_k;
        end
    end

    // ---- Stage: ring state and retire-mask registers ----
    always_ff @(posedge clk) begin
        if (reset) begin
            in_ptr       <= '0;
            out_ptr      <= '0;
            count        <= '0;
            commit_reg   <= '0;
            retire_count <= '0;
        end else begin
            in_ptr       <= in_ptr_nxt;
            out_ptr      <= out_ptr_nxt;
            count        <= count_nxt;
            commit_reg   <= ret_mask;
            retire_count <= ret_k[RCW-1:0];
        end
    end

endmodule

// File: tb/tb_commit_ring_ctrl.sv
module tb_commit_ring_ctrl;

    localparam int NCOMMIT  = 32;
    localparam int LNCOMMIT = 5;
    localparam int NDEC     = 4;
    localparam int NRETIRE  = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [LNCOMMIT-1:0] alloc_count;
    logic [NCOMMIT-1:0]  commit_done;
    logic                commit_br_enable;
    logic [LNCOMMIT-1:0] commit_br_addr;
    logic                commit_trap_br_enable;
    logic [LNCOMMIT-1:0] commit_trap_br_addr;
    logic [LNCOMMIT-1:0] next_start;
    logic [LNCOMMIT:0]   current_available;
    logic [NCOMMIT-1:0]  commit_reg;
    logic [2:0]          retire_count;
    logic                ring_empty;
    logic                ring_full;

    commit_ring_ctrl #(
        .NCOMMIT (NCOMMIT),
        .LNCOMMIT(LNCOMMIT),
        .NDEC    (NDEC),
        .NRETIRE (NRETIRE)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .alloc_count          (alloc_count),
        .commit_done          (commit_done),
        .commit_br_enable     (commit_br_enable),
        .commit_br_addr       (commit_br_addr),
        .commit_trap_br_enable(commit_trap_br_enable),
        .commit_trap_br_addr  (commit_trap_br_addr),
        .next_start           (next_start),
        .current_available    (current_available),
        .commit_reg           (commit_reg),
        .retire_count         (retire_count),
        .ring_empty           (ring_empty),
        .ring_full            (ring_full)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: live stations held in program order as a queue.
    int          model_q[$];
    int          m_out;
    logic [31:0] m_reg;
    int          m_rc;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        int pos;
        int avail_pre;
        int k;
        bit flush;
        avail_pre = NCOMMIT - model_q.size();
        m_reg = '0;
        k     = 0;
        flush = 0;
        if (reset) begin
            model_q.delete();
            m_out = 0;
            m_rc  = 0;
            return;
        end
        pos = -1;
        if (commit_trap_br_enable)
            for (int i = 0; i < model_q.size(); i++)
                if (model_q[i] == int'(commit_trap_br_addr)) pos = i;
        if (pos >= 0) begin
            flush = 1;
            while (model_q.size() > pos) model_q.delete(model_q.size() - 1);
            m_out = int'(commit_trap_br_addr);
        end else if (commit_br_enable) begin
            for (int i = 0; i < model_q.size(); i++)
                if (model_q[i] == int'(commit_br_addr)) pos = i;
            if (pos >= 0) begin
                flush = 1;
                while (model_q.size() > pos + 1) model_q.delete(model_q.size() - 1);
                m_out = (int'(commit_br_addr) + 1) % NCOMMIT;
            end
        end
        while (k < NRETIRE && model_q.size() > 0 && commit_done[model_q[0]]) begin
            m_reg[model_q[0]] = 1'b1;
            model_q.delete(0);
            k++;
        end
        if (!flush && int'(alloc_count) <= avail_pre && int'(alloc_count) <= 2 * NDEC) begin
            for (int i = 0; i < int'(alloc_count); i++) begin
                model_q.push_back(m_out);
                m_out = (m_out + 1) % NCOMMIT;
            end
        end
        m_rc = k;
    endtask

    task automatic check_model();
        chk("next_start", 64'(next_start), 64'(m_out));
        chk("current_available", 64'(current_available), 64'(NCOMMIT - model_q.size()));
        chk("ring_empty", 64'(ring_empty), 64'(model_q.size() == 0));
        chk("ring_full", 64'(ring_full), 64'(model_q.size() == NCOMMIT));
        chk("commit_reg", 64'(commit_reg), 64'(m_reg));
        chk("retire_count", 64'(retire_count), 64'(m_rc));
    endtask

    task automatic step(input int a, input logic [31:0] d, input logic be, input int ba,
                        input logic te, input int ta);
        reset                 = 1'b0;
        alloc_count           = LNCOMMIT'(a);
        commit_done           = d;
        commit_br_enable      = be;
        commit_br_addr        = LNCOMMIT'(ba);
        commit_trap_br_enable = te;
        commit_trap_br_addr   = LNCOMMIT'(ta);
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    // Reset is held while every other input tries to act; it must win.
    task automatic do_reset();
        reset                 = 1'b1;
        alloc_count           = 5'd5;
        commit_done           = '1;
        commit_br_enable      = 1'b1;
        commit_br_addr        = 5'd0;
        commit_trap_br_enable = 1'b1;
        commit_trap_br_addr   = 5'd1;
        @(posedge clk);
        model_edge();
        #1;
        check_model();
        chk("rst_next_start", 64'(next_start), 64'd0);
        chk("rst_available", 64'(current_available), 64'd32);
        chk("rst_empty", 64'(ring_empty), 64'd1);
        chk("rst_commit_reg", 64'(commit_reg), 64'd0);
        reset = 1'b0;
    endtask

    initial begin
        int a;
        int ba;
        int ta;
        logic be;
        logic te;
        logic [31:0] d;

        reset = 1'b1;
        alloc_count = '0;
        commit_done = '0;
        commit_br_enable = 1'b0;
        commit_br_addr = '0;
        commit_trap_br_enable = 1'b0;
        commit_trap_br_addr = '0;
        model_q.delete();
        m_out = 0;
        m_reg = '0;
        m_rc = 0;
        @(posedge clk);
        do_reset();

        // Basic allocate then retire three
        step(3, 32'h0, 0, 0, 0, 0);
        chk("t1_avail_after_alloc", 64'(current_available), 64'd29);
        step(0, 32'h7, 0, 0, 0, 0);
        chk("t1_commit_reg", 64'(commit_reg), 64'h7);
        chk("t1_retire_count", 64'(retire_count), 64'd3);
        chk("t1_next_start", 64'(next_start), 64'd3);
        chk("t1_empty", 64'(ring_empty), 64'd1);
        step(0, 32'h0, 0, 0, 0, 0);
        chk("t1_reg_one_cycle", 64'(commit_reg), 64'h0);

        // Fill to full, overflow dropped, drain four per clock
        do_reset();
        for (int i = 0; i < 4; i++) step(8, 32'h0, 0, 0, 0, 0);
        chk("t2_full", 64'(ring_full), 64'd1);
        chk("t2_avail", 64'(current_available), 64'd0);
        step(1, 32'h0, 0, 0, 0, 0);
        chk("t2_drop_next_start", 64'(next_start), 64'd0);
        step(0, 32'hFFFF_FFFF, 0, 0, 0, 0);
        chk("t2_first_drain", 64'(commit_reg), 64'hF);
        for (int i = 0; i < 7; i++) step(0, 32'hFFFF_FFFF, 0, 0, 0, 0);
        chk("t2_drained", 64'(ring_empty), 64'd1);

        // Wrap-around retire at stations 30,31,0,1
        do_reset();
        step(8, 32'h0, 0, 0, 0, 0);
        step(8, 32'h0, 0, 0, 0, 0);
        step(8, 32'h0, 0, 0, 0, 0);
        step(6, 32'h0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 32'hFFFF_FFFF, 0, 0, 0, 0);
        step(4, 32'h0, 0, 0, 0, 0);
        chk("t3_next_start", 64'(next_start), 64'd2);
        step(0, 32'hFFFF_FFFF, 0, 0, 0, 0);
        chk("t3_wrap_reg", 64'(commit_reg), 64'hC000_0003);
        chk("t3_empty", 64'(ring_empty), 64'd1);

        // In-order retire stops at the first incomplete station
        do_reset();
        step(6, 32'h0, 0, 0, 0, 0);
        step(0, 32'hB, 0, 0, 0, 0);
        chk("t4_partial", 64'(commit_reg), 64'h3);
        step(0, 32'hB, 0, 0, 0, 0);
        chk("t4_blocked", 64'(commit_reg), 64'h0);
        step(0, 32'hF, 0, 0, 0, 0);
        chk("t4_unblocked", 64'(commit_reg), 64'hC);

        // Branch flush with simultaneous alloc; non-live branch ignored
        do_reset();
        step(8, 32'h0, 0, 0, 0, 0);
        step(2, 32'h0, 0, 0, 0, 0);
        step(2, 32'h0, 1, 4, 0, 0);
        chk("t5_br_next_start", 64'(next_start), 64'd5);
        chk("t5_br_avail", 64'(current_available), 64'd27);
        step(0, 32'h0, 1, 12, 0, 0);
        chk("t5_br_ignored", 64'(next_start), 64'd5);

        // Trap at the oldest station empties the ring; trap beats branch
        do_reset();
        step(6, 32'h0, 0, 0, 0, 0);
        step(0, 32'h1, 0, 0, 1, 0);
        chk("t6_trap_empty", 64'(ring_empty), 64'd1);
        chk("t6_trap_reg", 64'(commit_reg), 64'h0);
        chk("t6_trap_next_start", 64'(next_start), 64'd0);
        step(6, 32'h0, 0, 0, 0, 0);
        step(0, 32'h0, 1, 4, 1, 2);
        chk("t6_trap_wins", 64'(next_start), 64'd2);
        chk("t6_trap_avail", 64'(current_available), 64'd30);

        // Randomized traffic against the queue model
        do_reset();
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                a  = $urandom_range(0, 2 * NDEC);
                d  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom | $urandom);
                be = ($urandom_range(0, 5) == 0);
                te = ($urandom_range(0, 11) == 0);
                ba = $urandom_range(0, NCOMMIT - 1);
                ta = $urandom_range(0, NCOMMIT - 1);
                if (model_q.size() > 0 && $urandom_range(0, 1) == 1)
                    ba = model_q[$urandom_range(0, model_q.size() - 1)];
                if (model_q.size() > 0 && $urandom_range(0, 1) == 1)
                    ta = model_q[$urandom_range(0, model_q.size() - 1)];
                step(a, d, be, ba, te, ta);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
